training_sequencer: RTL and testbench

- Control unit that drives the control inputs of the control-less forward/backward/training datapath.
- Fixed order per run:
  - initial-guess load from ROM;
  - repeated iterations, each one a pipeline wait, a weight update and a settling gap;
  - Manhattan phase 1, then Manhattan phase 2, then Adam;
  - best-weight readout.
- Sits beside the datapath top level. Its outputs connect one-to-one to the datapath flag inputs.

---
 rtl/training_sequencer_pkg.sv | 49 ++++
 rtl/seq_cycle_counter.sv | 34 +++
 rtl/training_sequencer.sv | 178 +++++++++++++++++
 tb/tb_training_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/training_sequencer_pkg.sv
// Shared state/phase encodings, registered output bundle and default iteration constants
// for the training sequencer.
package training_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    WAIT   = 3'd2,
    UPDATE = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5,
    DONE_S = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_M1   = 2'd0,
    PH_M2   = 2'd1,
    PH_ADAM = 2'd2
  } phase_e;

  typedef struct packed {
    logic rom_rd;
    logic stall;
    logic old_wt_rd;
    logic wr_train;
    logic mode;
    logic fin_m1;
    logic fin_m2;
    logic finished;
    logic busy;
    logic done;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{stall: 1'b1, mode: 1'b1, default: 1'b0};

  localparam int DEF_NUM_UNKNOWNS = 2;
  localparam int DEF_EXTRA_CYCLES = 3;
  localparam int DEF_PIPE_LATENCY = 6;
  localparam int DEF_M1_ITERS     = 4;
  localparam int DEF_M2_ITERS     = 4;
  localparam int DEF_ADAM_ITERS   = 8;
  localparam int DEF_CNT_W        = 8;

  // True when v is representable as an unsigned w-bit value.
  function automatic bit fits(input int v, input int w);
    return (v >= 0) && (v < (1 << w));
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter; zero_o flags the final cycle of a window.
// Load has priority; the count parks at zero until the next load.
module seq_cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/training_sequencer.sv
// Drives the datapath control flags: ROM load, M1/M2/Adam iterations, best-weight readout.
// Optional SEQ_ABORT_EN adds abort_i, which jumps any active window straight to FINISH.
module training_sequencer
  import training_sequencer_pkg::*;
#(
  parameter int NUM_UNKNOWNS = DEF_NUM_UNKNOWNS,
  parameter int EXTRA_CYCLES = DEF_EXTRA_CYCLES,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int M1_ITERS     = DEF_M1_ITERS,
  parameter int M2_ITERS     = DEF_M2_ITERS,
  parameter int ADAM_ITERS   = DEF_ADAM_ITERS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic training_done_i,
`ifdef SEQ_ABORT_EN
  input  logic abort_i,
`endif
  output logic initial_rom_read_flag_o,
  output logic stall_o,
  output logic old_weight_rd_o,
  output logic write_training_o,
  output logic training_mode_o,
  output logic finish_first_manhattan_iter_o,
  output logic finish_second_manhattan_iter_o,
  output logic finished_o,
  output logic busy_o,
  output logic done_o
);

  localparam bit CFG_OK = fits(NUM_UNKNOWNS - 1, CNT_W) && fits(PIPE_LATENCY - 1, CNT_W) &&
                          fits(EXTRA_CYCLES - 1, CNT_W) && (M1_ITERS >= 1) &&
                          (M2_ITERS >= 1) && (ADAM_ITERS >= 1) && fits(M1_ITERS, CNT_W) &&
                          fits(M2_ITERS, CNT_W) && fits(ADAM_ITERS, CNT_W);

  if (!CFG_OK) begin : g_cfg_err
    $error("training_sequencer: window length or iteration count does not fit CNT_W");
  end

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] iter_q, iter_d, iter_inc, phase_limit, cnt_val;
  logic             cnt_load, cnt_zero, abort_hit;
  seq_out_t         out_q, out_d;

`ifdef SEQ_ABORT_EN
  assign abort_hit = abort_i && (state_q != IDLE) && (state_q != DONE_S) && (state_q != FINISH);
`else
  assign abort_hit = 1'b0;
`endif

  assign iter_inc = iter_q + CNT_W'(1);

  always_comb begin
    phase_limit = CNT_W'(ADAM_ITERS);
    if (phase_q == PH_M1) phase_limit = CNT_W'(M1_ITERS);
    else if (phase_q == PH_M2) phase_limit = CNT_W'(M2_ITERS);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE, DONE_S: if (start_i) begin
        state_d = INIT;
        phase_d = PH_M1;
        iter_d  = '0;
      end
      INIT:    if (cnt_zero) state_d = WAIT;
      WAIT:    if (cnt_zero) state_d = UPDATE;
      UPDATE:  if (cnt_zero) state_d = GAP;
      GAP: if (cnt_zero) begin
        iter_d  = iter_inc;
        state_d = WAIT;
        if (training_done_i) begin
          state_d = FINISH;
        end else if (iter_inc == phase_limit) begin
          iter_d = '0;
          case (phase_q)
            PH_M1:   phase_d = PH_M2;
            PH_M2:   phase_d = PH_ADAM;
            default: state_d = FINISH;
          endcase
        end
      end
      FINISH:  if (cnt_zero) state_d = DONE_S;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = FINISH;
      phase_d = phase_q;
      iter_d  = iter_q;
    end
  end

  // Every state change is a new window, so the counter reloads on any transition.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      INIT, UPDATE, FINISH: cnt_val = CNT_W'(NUM_UNKNOWNS - 1);
      WAIT:                 cnt_val = CNT_W'(PIPE_LATENCY - 1);
      GAP:                  cnt_val = CNT_W'(EXTRA_CYCLES - 1);
      default:              cnt_val = '0;
    endcase
  end

  seq_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    out_d = OUT_RST;
    case (state_d)
      INIT: begin
        out_d.rom_rd = 1'b1;
        out_d.busy   = 1'b1;
      end
      WAIT: begin
        out_d.busy   = 1'b1;
        out_d.mode   = (phase_d != PH_ADAM);
        out_d.fin_m1 = (phase_q == PH_M1) && (phase_d == PH_M2);
        out_d.fin_m2 = (phase_q == PH_M2) && (phase_d == PH_ADAM);
      end
      UPDATE: begin
        out_d.busy      = 1'b1;
        out_d.stall     = 1'b0;
        out_d.old_wt_rd = 1'b1;
        out_d.wr_train  = 1'b1;
        out_d.mode      = (phase_d != PH_ADAM);
      end
      GAP: begin
        out_d.busy = 1'b1;
        out_d.mode = (phase_d != PH_ADAM);
      end
      FINISH: begin
        out_d.busy     = 1'b1;
        out_d.finished = 1'b1;
        out_d.mode     = out_q.mode;
      end
      DONE_S:  out_d.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= PH_M1;
      iter_q  <= '0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
      out_q   <= out_d;
    end
  end

  assign initial_rom_read_flag_o        = out_q.rom_rd;
  assign stall_o                        = out_q.stall;
  assign old_weight_rd_o                = out_q.old_wt_rd;
  assign write_training_o               = out_q.wr_train;
  assign training_mode_o                = out_q.mode;
  assign finish_first_manhattan_iter_o  = out_q.fin_m1;
  assign finish_second_manhattan_iter_o = out_q.fin_m2;
  assign finished_o                     = out_q.finished;
  assign busy_o                         = out_q.busy;
  assign done_o                         = out_q.done;

endmodule

// File: tb/tb_training_sequencer.sv
// Scoreboard bench: each run is planned cycle by cycle from the sequencing rules, the
// expected flags are queued as stimulus is applied and a negedge monitor compares them.
module tb_training_sequencer;

  localparam int NU = 2, PL = 6, EC = 3, M1 = 4, M2 = 4, AD = 8;

  typedef struct packed {
    logic rom, stall, oldrd, wrt, mode, ff1, ff2, fin, busy, done;
  } outs_t;

  typedef struct {
    outs_t exp;
    logic  start;
    logic  td;
    logic  abort;
  } step_t;

  localparam outs_t RST_V = '{stall: 1'b1, mode: 1'b1, default: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, td = 1'b0, abort = 1'b0;
  logic rom, stall, oldrd, wrt, mode, ff1, ff2, fin, busy, done;
  outs_t act;

  int checks = 0;
  int failures = 0;
  outs_t exp_q[$];
  step_t plan[$];

  always #5 clk = ~clk;

  training_sequencer dut (
    .clk_i                          (clk),
    .rst_ni                         (rst_n),
    .start_i                        (start),
    .training_done_i                (td),
`ifdef SEQ_ABORT_EN
    .abort_i                        (abort),
`endif
    .initial_rom_read_flag_o        (rom),
    .stall_o                        (stall),
    .old_weight_rd_o                (oldrd),
    .write_training_o               (wrt),
    .training_mode_o                (mode),
    .finish_first_manhattan_iter_o  (ff1),
    .finish_second_manhattan_iter_o (ff2),
    .finished_o                     (fin),
    .busy_o                         (busy),
    .done_o                         (done)
  );

  assign act = {rom, stall, oldrd, wrt, mode, ff1, ff2, fin, busy, done};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, e);
      end
    end
  end

  function automatic step_t busy_step(input logic m);
    step_t s;
    s.exp      = '0;
    s.exp.busy = 1'b1;
    s.exp.stall = 1'b1;
    s.exp.mode = m;
    s.start    = 1'($urandom_range(0, 1));
    s.td       = 1'($urandom_range(0, 1));
    s.abort    = 1'b0;
    return s;
  endfunction

  // Index 0 is the START cycle; a run stops after iteration td_iter (0 = never) or at abort_at.
  task automatic build_plan(input int td_iter, input int abort_at, input bit from_done);
    step_t s;
    logic  m;
    plan.delete();
    s.exp = RST_V;
    s.exp.done = from_done;
    s.start = 1'b1;
    s.td = 1'($urandom_range(0, 1));
    s.abort = 1'b0;
    plan.push_back(s);
    for (int j = 0; j < NU; j++) begin
      s = busy_step(1'b1);
      s.exp.rom = 1'b1;
      plan.push_back(s);
    end
    for (int k = 1; k <= M1 + M2 + AD; k++) begin
      m = (k <= M1 + M2);
      for (int j = 0; j < PL; j++) begin
        s = busy_step(m);
        s.exp.ff1 = (j == 0) && (k == M1 + 1);
        s.exp.ff2 = (j == 0) && (k == M1 + M2 + 1);
        plan.push_back(s);
      end
      for (int j = 0; j < NU; j++) begin
        s = busy_step(m);
        s.exp.stall = 1'b0;
        s.exp.oldrd = 1'b1;
        s.exp.wrt = 1'b1;
        plan.push_back(s);
      end
      for (int j = 0; j < EC; j++) begin
        s = busy_step(m);
        if (j == EC - 1) s.td = (k == td_iter);
        plan.push_back(s);
      end
      if (k == td_iter) break;
    end
    if (abort_at > 0 && abort_at < plan.size()) begin
      plan[abort_at].abort = 1'b1;
      while (plan.size() > abort_at + 1) void'(plan.pop_back());
    end
    m = plan[plan.size() - 1].exp.mode;
    for (int j = 0; j < NU; j++) begin
      s = busy_step(m);
      s.exp.fin = 1'b1;
      plan.push_back(s);
    end
    for (int j = 0; j < 2; j++) begin
      s.exp = RST_V;
      s.exp.done = 1'b1;
      s.start = 1'b0;
      s.td = 1'($urandom_range(0, 1));
      s.abort = 1'b0;
      plan.push_back(s);
    end
  endtask

  task automatic run_plan(input int reset_at);
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act !== RST_V) begin
          failures++;
          $display("FAIL async_reset t=%0t actual=%b required=%b", $time, act, RST_V);
        end
        start = 1'b0;
        td = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      exp_q.push_back(plan[i].exp);
      start = plan[i].start;
      td    = plan[i].td;
      abort = plan[i].abort;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit fd;
    int rst_at;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (act !== RST_V) begin
      failures++;
      $display("FAIL reset_values actual=%b required=%b", act, RST_V);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    build_plan(0, 0, 1'b0);  run_plan(-1);   // full run to iteration limits
    build_plan(3, 0, 1'b1);  run_plan(-1);   // restart from DONE_S, early TRAINING_DONE
    build_plan(0, 0, 1'b1);  run_plan(53);   // reset mid-UPDATE
    build_plan(0, 0, 1'b0);  run_plan(-1);   // replay after reset
    build_plan(4, 0, 1'b1);  run_plan(-1);   // done at M1 end: no pulse
`ifdef SEQ_ABORT_EN
    build_plan(0, 20, 1'b1); run_plan(-1);
    build_plan(9, 60, 1'b1); run_plan(-1);
`endif
    fd = 1'b1;
    for (int r = 0; r < 6; r++) begin
      build_plan(int'($urandom_range(0, M1 + M2 + AD)), 0, fd);
      rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, plan.size() - 1)) : -1;
      run_plan(rst_at);
      fd = (rst_at < 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
